par2serial_tx: RTL and testbench
================================

# par2serial_tx

Parallel-to-serial transmit stage that consumes the 9-bit `{valid, data[7:0]}` word produced by the 2:1 lane multiplexer and serialises it onto a single bit line. The block runs on the bit clock: it samples one word every 8 cycles and shifts it out one bit per cycle. When no valid data is present it transmits the COM symbol (0xBC) as idle fill. After every reset it sends a fixed preamble of COM symbols before it accepts data.

## Interface

Parameters:
- `SYNC_WORDS`, default 4: number of COM symbols forced after reset before data is accepted; legal range 1..15.
- `COM_SYM`, default 8'hBC: idle/sync symbol value.

Ports:
- `clk`, input, 1: bit clock; all state is updated on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in`, input, 9: `in[8]` is the valid flag, `in[7:0]` is the data byte.
- `out`, output, 1: serial bit, registered.
- `sym_start`, output, 1: high during the cycle in which the first bit of a symbol is on `out`.
- `load_ack`, output, 1: high for one cycle after a valid input byte has been consumed.
- `active`, output, 1: high once the sync preamble has completed.

## Operation

- State machine has two states:
  - SYNC (the reset state): every loaded symbol is `COM_SYM`, regardless of `in`.
  - ACTIVE: symbols come from `in`.
- A 3-bit bit counter `bit_cnt` wraps 7→0. A load edge is any rising edge with `bit_cnt==0`.
- At a load edge in SYNC:
  - The shift register is loaded with `COM_SYM` and `sync_cnt` increments.
  - If `sync_cnt==SYNC_WORDS-1` before the increment, the state moves to ACTIVE.
- At a load edge in ACTIVE:
  - If `in[8]==1`: load `in[7:0]` and set `load_ack=1`.
  - Otherwise: load `COM_SYM` and set `load_ack=0`.
- On non-load edges the shift register advances by one bit, and `load_ack` and `sym_start` return to 0.
- `in` is sampled only at load edges. Changes on `in` between load edges are ignored.
- `active` equals the state being ACTIVE (registered).
- Reset values: `out=0`, `sym_start=0`, `load_ack=0`, `active=0`, `bit_cnt=0`, `sync_cnt=0`, state SYNC, shift register 0.

## Timing

- Latency: a word sampled at load edge E has its first bit on `out` from E to E+1, and its last bit from E+7 to E+8.
- The next load edge is E+8. Symbols are back-to-back with no gap.
- `sym_start` and `load_ack` are set at the load edge and stay high for exactly the following cycle.
- The first load edge is the first rising edge after `reset` deasserts.
- The preamble occupies 8·`SYNC_WORDS` cycles. `active` rises at the load edge that loads the last preamble COM.
  - The first data byte is sampled at the next load edge after that.
- Reset asserted mid-symbol:
  - All outputs clear immediately, without waiting for a clock edge.
  - The partial symbol is discarded.
  - The preamble restarts from zero after release.
- A valid input present during SYNC is not consumed and `load_ack` stays 0. The upstream stage must hold the word; it is taken at the first ACTIVE load edge if still valid.
- Continuous valid input: `load_ack` pulses once every 8 cycles.

## Configuration

- Macro `SER_LSB_FIRST_EN`:
  - Defined: bit 0 of each symbol is transmitted first. COM 0xBC appears on `out` as 0,0,1,1,1,1,0,1.
  - Undefined (default): MSB first. COM appears as 1,0,1,1,1,1,0,0.
- The macro affects the shift direction only. Timing, `sym_start` and `load_ack` are identical in both builds.

## Test plan

- Reset check: hold `reset=1` for 3 cycles with `in=9'h1FF` → `out=0`, `sym_start=0`, `load_ack=0`, `active=0` throughout.
- Preamble (`SYNC_WORDS=4`, `in=9'h1A5` held from release):
  - First 32 bits are four 10111100 patterns and `load_ack` stays 0.
  - `active` rises at the 4th load edge.
  - The next symbol is 10100101 with a `load_ack` pulse.
- Idle fill: in ACTIVE with `in=9'h0A5` (valid=0) → `out` repeats 10111100, `load_ack=0`, `sym_start` pulses every 8 cycles.
- Mid-symbol input change: `in` switches from 9'h155 to 9'h1F0 three cycles after a load edge → the current symbol completes as 01010101, and the next symbol is 11110000.
- Reset mid-operation: assert `reset` 4 bits into a data symbol → `out` drops to 0 at once; after release the full 4-COM preamble repeats before data resumes.
- `SER_LSB_FIRST_EN` build: `in=9'h101` → `out` sequence is 1,0,0,0,0,0,0,0; COM is 0,0,1,1,1,1,0,1.

Source files
------------

// File: rtl/par2serial_tx.sv
// Parallel-to-serial transmitter: one 8-bit symbol every 8 bit clocks, COM preamble after reset, COM idle fill.
// Optional macro SER_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_SYNC   | preamble: every loaded symbol is COM_SYM, input is ignored
// S_ACTIVE | symbols taken from in[7:0] when in[8] is set, else COM_SYM

module par2serial_tx #(
    parameter int unsigned SYNC_WORDS = 4,
    parameter logic [7:0]  COM_SYM    = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] in,
    output logic       out,
    output logic       sym_start,
    output logic       load_ack,
    output logic       active
);

    typedef enum logic {
        S_SYNC   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt, sync_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] word;
    logic       load;
    logic       out_nxt;
    logic       sym_start_nxt;
    logic       load_ack_nxt;

    assign load = (bit_cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sync_cnt_nxt  = sync_cnt;
        word          = COM_SYM;
        load_ack_nxt  = 1'b0;
        sym_start_nxt = load;
        if (load) begin
            case (state)
                S_SYNC: begin
                    sync_cnt_nxt = sync_cnt + 4'd1;
                    if (sync_cnt == SYNC_LAST) begin
                        state_nxt = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (in[8]) begin
                        word         = in[7:0];
                        load_ack_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_SYNC;
            endcase
        end
    end

    // The first bit of a new word goes straight to out; shreg holds the remaining seven.
    always_comb begin
`ifdef SER_LSB_FIRST_EN
        if (load) begin
            out_nxt   = word[0];
            shreg_nxt = {1'b0, word[7:1]};
        end else begin
            out_nxt   = shreg[0];
            shreg_nxt = {1'b0, shreg[7:1]};
        end
`else
        if (load) begin
            out_nxt   = word[7];
            shreg_nxt = {word[6:0], 1'b0};
        end else begin
            out_nxt   = shreg[7];
            shreg_nxt = {shreg[6:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            sync_cnt  <= 4'd0;
            shreg     <= 8'd0;
            out       <= 1'b0;
            sym_start <= 1'b0;
            load_ack  <= 1'b0;
            active    <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            sync_cnt  <= sync_cnt_nxt;
            shreg     <= shreg_nxt;
            out       <= out_nxt;
            sym_start <= sym_start_nxt;
            load_ack  <= load_ack_nxt;
            active    <= (state_nxt == S_ACTIVE);
        end
    end

endmodule

// File: tb/tb_par2serial_tx.sv
// Self-checking bench for par2serial_tx: symbol-level table, hand sequences, randomized words
// checked every cycle against a cycle-count reference model.

module tb_par2serial_tx;

    localparam int          SW  = 4;
    localparam logic [7:0]  COM = 8'hBC;
`ifdef SER_LSB_FIRST_EN
    localparam logic EXP_FB_COM = 1'b0;
    localparam logic EXP_FB_01  = 1'b1;
`else
    localparam logic EXP_FB_COM = 1'b1;
    localparam logic EXP_FB_01  = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] in    = 9'h000;
    logic       out, sym_start, load_ack, active;

    par2serial_tx #(.SYNC_WORDS(SW), .COM_SYM(COM)) dut (
        .clk(clk), .reset(reset), .in(in),
        .out(out), .sym_start(sym_start), .load_ack(load_ack), .active(active)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t counts edges since reset release; symbol index = t/8, bit index = t%8.
    int         t = -1;
    int         idx;
    logic [7:0] m_word = 8'h00;
    logic       e_out = 1'b0, e_sym = 1'b0, e_ack = 1'b0, e_act = 1'b0;

    function automatic logic bit_of(input logic [7:0] w, input int k);
`ifdef SER_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = -1; m_word = 8'h00;
            e_out = 1'b0; e_sym = 1'b0; e_ack = 1'b0; e_act = 1'b0;
        end else begin
            t++;
            if (t % 8 == 0) begin
                idx    = t / 8;
                m_word = (idx >= SW && in[8]) ? in[7:0] : COM;
                e_ack  = (idx >= SW) && in[8];
                e_sym  = 1'b1;
                if (idx >= SW - 1) e_act = 1'b1;
            end else begin
                e_sym = 1'b0;
                e_ack = 1'b0;
            end
            e_out = bit_of(m_word, t % 8);
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out", out, e_out);
            check("cyc_sym_start", sym_start, e_sym);
            check("cyc_load_ack", load_ack, e_ack);
            check("cyc_active", active, e_act);
        end
    end

    // Call just after the negedge preceding a load edge; returns the reassembled symbol.
    task automatic get_sym(output logic [7:0] s, output logic ack0, output logic act0,
                           output logic ss0, output logic fb);
        s = 8'h00; ack0 = 1'b0; act0 = 1'b0; ss0 = 1'b0; fb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef SER_LSB_FIRST_EN
            s[k] = out;
`else
            s[7-k] = out;
`endif
            if (k == 0) begin
                ack0 = load_ack; act0 = active; ss0 = sym_start; fb = out;
            end
        end
    endtask

    typedef struct {
        logic [8:0] vin;
        logic [7:0] sym;
        logic       ack;
    } vec_t;

    vec_t tbl [6];

    logic [7:0] s, s2;
    logic       a0, ac0, ss0, fb, a2, ac2, ss2, fb2;
    logic [8:0] in_at_load;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout expected none");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{9'h1FF, 8'hFF, 1'b1};
        tbl[1] = '{9'h100, 8'h00, 1'b1};
        tbl[2] = '{9'h0FF, COM,   1'b0};
        tbl[3] = '{9'h13C, 8'h3C, 1'b1};
        tbl[4] = '{9'h000, COM,   1'b0};
        tbl[5] = '{9'h1BC, 8'hBC, 1'b1};

        // Reset held with all-ones input
        reset = 1'b1; in = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", out, 0);
            check("rst_sym_start", sym_start, 0);
            check("rst_load_ack", load_ack, 0);
            check("rst_active", active, 0);
        end

        // Preamble with a valid word waiting
        in = 9'h1A5; reset = 1'b0; chk_en = 1'b1;
        for (int i = 0; i < SW; i++) begin
            get_sym(s, a0, ac0, ss0, fb);
            check("pre_sym", s, COM);
            check("pre_ack", a0, 0);
            check("pre_sym_start", ss0, 1);
            check("pre_active", ac0, (i == SW - 1) ? 1 : 0);
            if (i == 0) check("pre_first_bit", fb, EXP_FB_COM);
        end
        get_sym(s, a0, ac0, ss0, fb);
        check("first_data_sym", s, 8'hA5);
        check("first_data_ack", a0, 1);

        // Idle fill
        in = 9'h0A5;
        for (int i = 0; i < 3; i++) begin
            get_sym(s, a0, ac0, ss0, fb);
            check("idle_sym", s, COM);
            check("idle_ack", a0, 0);
            check("idle_sym_start", ss0, 1);
        end

        // Table of single-symbol vectors
        for (int i = 0; i < 6; i++) begin
            in = tbl[i].vin;
            get_sym(s, a0, ac0, ss0, fb);
            check($sformatf("tbl%0d_sym", i), s, tbl[i].sym);
            check($sformatf("tbl%0d_ack", i), a0, tbl[i].ack);
        end

        // Bit order of 0x01
        in = 9'h101;
        get_sym(s, a0, ac0, ss0, fb);
        check("order_sym", s, 8'h01);
        check("order_first_bit", fb, EXP_FB_01);

        // Input change mid-symbol is ignored until the next load edge
        in = 9'h155;
        fork
            get_sym(s, a0, ac0, ss0, fb);
            begin
                repeat (3) @(negedge clk);
                in = 9'h1F0;
            end
        join
        check("mid_cur_sym", s, 8'h55);
        get_sym(s2, a2, ac2, ss2, fb2);
        check("mid_next_sym", s2, 8'hF0);
        check("mid_next_ack", a2, 1);

        // Randomized words with random mid-symbol disturbance
        for (int i = 0; i < 40; i++) begin
            in = {1'($urandom_range(0, 1)), 8'($urandom)};
            in_at_load = in;
            fork
                get_sym(s, a0, ac0, ss0, fb);
                begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    in = {1'($urandom_range(0, 1)), 8'($urandom)};
                end
            join
            check("rnd_sym", s, in_at_load[8] ? in_at_load[7:0] : COM);
            check("rnd_ack", a0, in_at_load[8]);
        end

        // Reset four bits into an all-ones symbol
        in = 9'h1FF;
        repeat (4) @(negedge clk);
        check("pre_rst_out", out, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_active", active, 0);
        check("async_rst_sym_start", sym_start, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < SW; i++) begin
            get_sym(s, a0, ac0, ss0, fb);
            check("re_pre_sym", s, COM);
            check("re_pre_ack", a0, 0);
        end
        get_sym(s, a0, ac0, ss0, fb);
        check("re_data_sym", s, 8'hFF);
        check("re_data_ack", a0, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
